// File: rtl/filtro_biquad_seq.sv
// Sequential direct-form-II biquad that shares one signed W x W multiplier over an 8-state schedule.
// Define FILTRO_BIQUAD_SAT_EN to saturate w and y; without it they wrap to W bits.
module filtro_biquad_seq #(
    parameter int W    = 25,
    parameter int FRAC = 10
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] u,
    output logic signed [W-1:0] y,
    output logic                out_valid,
    input  logic                coef_we,
    input  logic [2:0]          coef_addr,
    input  logic signed [W-1:0] coef_data
);
    localparam int AW = 2*W + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_A1, S_A2, S_WCALC, S_B0, S_B1, S_B2, S_DONE
    } state_t;

    state_t               state_q;
    logic signed [AW-1:0] acc_q;
    logic signed [W-1:0]  u_q, w_q, w1_q, w2_q, y_q;
    logic                 out_valid_q;
    // Coefficient slots: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
    logic signed [W-1:0]  coef_q [5];

    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  prod_ext, acc_sh;
    logic signed [AW:0]    w_sum, y_sum;

    assign in_ready  = Reset & Enable & (state_q == S_IDLE);
    assign y         = y_q;
    assign out_valid = out_valid_q;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_A1:    begin mul_a = coef_q[3]; mul_b = w1_q; end
            S_A2:    begin mul_a = coef_q[4]; mul_b = w2_q; end
            S_B0:    begin mul_a = coef_q[0]; mul_b = w_q;  end
            S_B1:    begin mul_a = coef_q[1]; mul_b = w1_q; end
            S_B2:    begin mul_a = coef_q[2]; mul_b = w2_q; end
            default: begin mul_a = '0;        mul_b = '0;   end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = {{3{prod[2*W-1]}}, prod};
    assign acc_sh   = acc_q >>> FRAC;
    assign w_sum    = {{(AW+1-W){u_q[W-1]}}, u_q} + {acc_sh[AW-1], acc_sh};
    assign y_sum    = {acc_sh[AW-1], acc_sh};

`ifdef FILTRO_BIQUAD_SAT_EN
    localparam logic signed [AW:0] FMAX = $signed({{(AW-W+2){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [AW:0] FMIN = $signed({{(AW-W+2){1'b1}}, {(W-1){1'b0}}});

    function automatic logic signed [W-1:0] fit(input logic signed [AW:0] v);
        if (v > FMAX)
            return FMAX[W-1:0];
        else if (v < FMIN)
            return FMIN[W-1:0];
        else
            return v[W-1:0];
    endfunction
`else
    function automatic logic signed [W-1:0] fit(input logic signed [AW:0] v);
        return v[W-1:0];
    endfunction
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 5; i++) coef_q[i] <= '0;
        end else if (coef_we && coef_addr < 3'd5) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            u_q         <= '0;
            w_q         <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (Enable) begin
                case (state_q)
                    S_IDLE: begin
                        if (in_valid && in_ready) begin
                            u_q     <= u;
                            state_q <= S_A1;
                        end
                    end
                    S_A1: begin
                        acc_q   <= prod_ext;
                        state_q <= S_A2;
                    end
                    S_A2: begin
                        acc_q   <= acc_q + prod_ext;
                        state_q <= S_WCALC;
                    end
                    S_WCALC: begin
                        w_q     <= fit(w_sum);
                        state_q <= S_B0;
                    end
                    S_B0: begin
                        acc_q   <= prod_ext;
                        state_q <= S_B1;
                    end
                    S_B1: begin
                        acc_q   <= acc_q + prod_ext;
                        state_q <= S_B2;
                    end
                    S_B2: begin
                        acc_q   <= acc_q + prod_ext;
                        state_q <= S_DONE;
                    end
                    S_DONE: begin
                        y_q         <= fit(y_sum);
                        w2_q        <= w1_q;
                        w1_q        <= w_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_filtro_biquad_seq.sv
// Directed-vector bench for filtro_biquad_seq: the driver queues expected (y, cycle) pairs,
// and a monitor pops and compares them on every out_valid pulse.
module tb_filtro_biquad_seq;
    localparam int W    = 25;
    localparam int FRAC = 10;

    logic                CLK, Reset, Enable, in_valid, in_ready, out_valid, coef_we;
    logic signed [W-1:0] u, y, coef_data;
    logic [2:0]          coef_addr;

    filtro_biquad_seq #(.W(W), .FRAC(FRAC)) dut (
        .CLK(CLK), .Reset(Reset), .Enable(Enable), .in_valid(in_valid), .in_ready(in_ready),
        .u(u), .y(y), .out_valid(out_valid), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data)
    );

    typedef struct {
        logic signed [W-1:0] y;
        int                  when;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: one comparison of value and one of arrival cycle per output pulse
    always @(negedge CLK) begin
        if (Reset && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid cycle %0d got y=%0d required none", cyc, y);
            end else begin
                mon_e = sb_q.pop_front();
                checks++;
                if (y !== mon_e.y) begin
                    errors++;
                    $display("FAIL y_value cycle %0d got %0d required %0d", cyc, y, mon_e.y);
                end else begin
                    $display("out y=%0d at cycle %0d", y, cyc);
                end
                checks++;
                if (cyc != mon_e.when) begin
                    errors++;
                    $display("FAIL out_latency got cycle %0d required cycle %0d", cyc, mon_e.when);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        Enable   = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        Reset    = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got %b required 0", in_ready);
        end
        checks++;
        if (y !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got y=%0d ov=%b required y=0 ov=0", y, out_valid);
        end
        Reset = 1'b1;
    endtask

    task automatic wcoef(input logic [2:0] a, input int d);
        @(negedge CLK);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d[W-1:0];
        @(negedge CLK);
        coef_we   = 1'b0;
    endtask

    // Returns on the negedge of the cycle after the accepting one.
    task automatic send(input int val, input int expv, input bit push, input int extra);
        bit done;
        exp_t e;
        done = 1'b0;
        @(negedge CLK);
        in_valid = 1'b1;
        u        = val[W-1:0];
        for (int k = 0; k < 40 && !done; k++) begin
            if (in_ready) begin
                done = 1'b1;
                $display("in u=%0d accepted at cycle %0d", val, cyc);
                if (push) begin
                    e.y    = expv[W-1:0];
                    e.when = cyc + 8 + extra;
                    sb_q.push_back(e);
                end
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout u=%0d got no in_ready required accept", val);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(negedge CLK);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending outputs required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (10) @(negedge CLK);
    endtask

    initial begin
        int   accepts;
        int   sat_exp;
        logic exp_rdy;
        Reset = 1'b0; Enable = 1'b1; in_valid = 1'b0; u = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        // Pass-through gain 1.0; writes to addresses 5-7 must not disturb b1/b2/a1/a2
        do_reset();
        wcoef(3'd0, 1024);
        send(100, 100, 1'b1, 0);
        wcoef(3'd5, 4096);
        wcoef(3'd6, 4096);
        wcoef(3'd7, 4096);
        send(-37, -37, 1'b1, 0);
        drain();

        // Integrator: a1 = 1.0 feeds w1 back
        do_reset();
        wcoef(3'd0, 1024);
        wcoef(3'd3, 1024);
        send(10, 10, 1'b1, 0);
        send(10, 20, 1'b1, 0);
        send(10, 30, 1'b1, 0);
        drain();

        // Gain 2.0 pushes 2^23 to 2^24, one past the positive limit
`ifdef FILTRO_BIQUAD_SAT_EN
        sat_exp = (1 << 24) - 1;
`else
        sat_exp = -(1 << 24);
`endif
        do_reset();
        wcoef(3'd0, 2048);
        send(1 << 23, sat_exp, 1'b1, 0);
        drain();

        // in_valid held for 20 cycles: accepts only at offsets 0, 8, 16
        do_reset();
        wcoef(3'd0, 1024);
        @(negedge CLK);
        in_valid = 1'b1;
        u        = 25'sd5;
        accepts  = 0;
        for (int i = 0; i < 20; i++) begin
            exp_rdy = ((i % 8) == 0);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL ready_pattern offset %0d got %b required %b", i, in_ready, exp_rdy);
            end
            if (in_ready) begin
                accepts++;
                $display("in u=5 accepted at cycle %0d", cyc);
                sb_q.push_back('{25'sd5, cyc + 8});
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
        checks++;
        if (accepts != 3) begin
            errors++;
            $display("FAIL accept_count got %0d required 3", accepts);
        end
        drain();

        // Reset during B0 drops the sample and clears delay line and coefficients
        do_reset();
        wcoef(3'd0, 1024);
        wcoef(3'd3, 1024);
        send(55, 55, 1'b1, 0);
        drain();
        send(66, 0, 1'b0, 0);
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        checks++;
        if (y !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset got y=%0d rdy=%b required y=0 rdy=0", y, in_ready);
        end
        Reset = 1'b1;
        wcoef(3'd1, 1024);
        wcoef(3'd2, 1024);
        send(9, 0, 1'b1, 0);
        drain();

        // Enable low for 5 cycles while in A2 delays the output by 5 cycles
        do_reset();
        wcoef(3'd0, 1024);
        wcoef(3'd3, 512);
        send(40, 40, 1'b1, 0);
        send(10, 30, 1'b1, 5);
        @(negedge CLK);
        Enable = 1'b0;
        repeat (5) @(negedge CLK);
        Enable = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
